// File: rtl/vga_scan_gen.sv
// 640x480@60 VGA raster generator: pixel counters, syncs, blank, and per-frame strobes.
// Optional VGA_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module vga_scan_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       frame_start,
  output logic       vblank_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic       pix_phase;
  logic       advance;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       hs_next;
  logic       vs_next;
  logic       blank_n_next;
  logic       frame_start_next;
  logic       vblank_start_next;

  // Next-count computation; all sync/blank/strobe outputs derive from these values
  always_comb begin
    advance = pix_phase;
    x_next  = DrawX;
    y_next  = DrawY;
    if (advance) begin
      if (DrawX == H_LAST) begin
        x_next = 10'd0;
        if (DrawY == V_LAST) begin
          y_next = 10'd0;
        end else begin
          y_next = DrawY + 10'd1;
        end
      end else begin
        x_next = DrawX + 10'd1;
      end
    end else begin
      x_next = DrawX;
    end
    hs_next           = !((x_next >= H_SYNC_START) && (x_next < H_SYNC_END));
    vs_next           = !((y_next >= V_SYNC_START) && (y_next < V_SYNC_END));
    blank_n_next      = (x_next < H_VIS) && (y_next < V_VIS);
    frame_start_next  = advance && (x_next == 10'd0) && (y_next == 10'd0);
    vblank_start_next = advance && (x_next == 10'd0) && (y_next == V_VIS);
  end

  // Counters and timing outputs registered together so they stay aligned
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_phase    <= 1'b0;
      VGA_CLK      <= 1'b1;
      DrawX        <= 10'd0;
      DrawY        <= 10'd0;
      VGA_HS       <= 1'b1;
      VGA_VS       <= 1'b1;
      VGA_BLANK_N  <= 1'b1;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      pix_phase    <= ~pix_phase;
      // VGA_CLK tracks the complement of the next pix_phase value
      VGA_CLK      <= pix_phase;
      DrawX        <= x_next;
      DrawY        <= y_next;
      VGA_HS       <= hs_next;
      VGA_VS       <= vs_next;
      VGA_BLANK_N  <= blank_n_next;
      frame_start  <= frame_start_next;
      vblank_start <= vblank_start_next;
    end
  end

  assign VGA_SYNC_N = 1'b0;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_r;

  // Completed-frame counter, steps in the same cycle frame_start rises
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_cnt_r <= 16'd0;
    end else if (frame_start_next) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: default-size instance for line timing, reduced-size
// instance (16x12 totals) for whole-frame, strobe, reset and frame counter checks.
module tb_vga_scan_gen;

  logic Clk;
  logic rst_d;
  logic rst_s;

  logic [9:0] dx_d, dy_d, dx_s, dy_s;
  logic vclk_d, hs_d, vs_d, bn_d, sn_d, fs_d, vb_d;
  logic vclk_s, hs_s, vs_s, bn_s, sn_s, fs_s, vb_s;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc_d, fc_s;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_d = 0;
  int n_s = 0;
  logic [15:0] exp_fc = 16'd0;

  vga_scan_gen dut_d (
    .Clk(Clk), .Reset(rst_d), .DrawX(dx_d), .DrawY(dy_d), .VGA_CLK(vclk_d),
    .VGA_HS(hs_d), .VGA_VS(vs_d), .VGA_BLANK_N(bn_d), .VGA_SYNC_N(sn_d),
    .frame_start(fs_d), .vblank_start(vb_d)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_d)
`endif
  );

  vga_scan_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .Clk(Clk), .Reset(rst_s), .DrawX(dx_s), .DrawY(dy_s), .VGA_CLK(vclk_s),
    .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(bn_s), .VGA_SYNC_N(sn_s),
    .frame_start(fs_s), .vblank_start(vb_s)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  typedef struct {
    int         n;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       fs;
    logic       vb;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (n_d=%0d n_s=%0d)", name, act, exp, n_d, n_s);
    end
  endtask

  // Small instance: 16 pixels/line, 12 lines/frame, 384 Clk per frame
  task automatic check_small();
    int p, x, y;
    p = n_s / 2;
    x = p % 16;
    y = (p / 16) % 12;
    chk("s_drawx", 32'(dx_s), 32'(x));
    chk("s_drawy", 32'(dy_s), 32'(y));
    chk("s_hs", 32'(hs_s), 32'(!(x >= 10 && x <= 12)));
    chk("s_vs", 32'(vs_s), 32'(!(y >= 8 && y <= 9)));
    chk("s_blank_n", 32'(bn_s), 32'(x < 8 && y < 6));
    chk("s_frame_start", 32'(fs_s), 32'(n_s > 0 && (n_s % 384) == 0));
    chk("s_vblank_start", 32'(vb_s), 32'((n_s % 384) == 192));
    chk("s_vga_clk", 32'(vclk_s), 32'((n_s % 2) == 0));
`ifdef VGA_FRAME_CNT_EN
    chk("s_frame_cnt", 32'(fc_s), 32'(exp_fc));
`endif
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    if (rst_d) n_d = 0; else n_d++;
    if (rst_s) begin
      n_s = 0;
      exp_fc = 16'd0;
    end else begin
      n_s++;
      if ((n_s % 384) == 0) exp_fc = exp_fc + 16'd1;
    end
    chk("d_sync_n", 32'(sn_d), 32'd0);
    chk("s_sync_n", 32'(sn_s), 32'd0);
    chk("d_vga_clk", 32'(vclk_d), 32'((n_d % 2) == 0));
    check_small();
  endtask

  initial begin
    vecs[0]  = '{0,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4,    10'd2,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1279, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1280, 10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1311, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1312, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1503, 10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1504, 10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1599, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1600, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1602, 10'd1,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (4) tick();
    rst_d = 1'b0;
    rst_s = 1'b0;

    // Default-size line timing from the table; small instance is checked every tick
    for (int i = 0; i < 14; i++) begin
      while (n_d < vecs[i].n) tick();
      chk("d_drawx", 32'(dx_d), 32'(vecs[i].x));
      chk("d_drawy", 32'(dy_d), 32'(vecs[i].y));
      chk("d_hs", 32'(hs_d), 32'(vecs[i].hs));
      chk("d_vs", 32'(vs_d), 32'(vecs[i].vs));
      chk("d_blank_n", 32'(bn_d), 32'(vecs[i].bn));
      chk("d_frame_start", 32'(fs_d), 32'(vecs[i].fs));
      chk("d_vblank_start", 32'(vb_d), 32'(vecs[i].vb));
    end

    // Mid-frame asynchronous reset on the small instance at (5,3)
    for (int k = 0; k < 400 && (n_s % 384) != 106; k++) tick();
    chk("s_reset_point", 32'(n_s % 384), 32'd106);
    chk("s_pre_reset_x", 32'(dx_s), 32'd5);
    #4;
    rst_s = 1'b1;
    #1;
    chk("s_async_drawx", 32'(dx_s), 32'd0);
    chk("s_async_drawy", 32'(dy_s), 32'd0);
    chk("s_async_hs", 32'(hs_s), 32'd1);
    chk("s_async_vs", 32'(vs_s), 32'd1);
    chk("s_async_blank_n", 32'(bn_s), 32'd1);
    chk("s_async_frame_start", 32'(fs_s), 32'd0);
    chk("s_async_vblank_start", 32'(vb_s), 32'd0);
    chk("s_async_vga_clk", 32'(vclk_s), 32'd1);
`ifdef VGA_FRAME_CNT_EN
    chk("s_async_frame_cnt", 32'(fc_s), 32'd0);
`endif
    tick();
    rst_s = 1'b0;
    // Three full frames after release; frame_start first at 384 Clk
    repeat (3 * 384 + 4) tick();

`ifdef VGA_FRAME_CNT_EN
    chk("s_frame_cnt_three", 32'(fc_s), 32'd3);
    force dut_s.frame_cnt_r = 16'hFFFF;
    #1;
    release dut_s.frame_cnt_r;
    exp_fc = 16'hFFFF;
    chk("s_frame_cnt_preload", 32'(fc_s), 32'hFFFF);
    for (int k = 0; k < 400 && !(n_s > 0 && (n_s % 384) == 0); k++) tick();
    chk("s_frame_cnt_wrap", 32'(fc_s), 32'd0);
    chk("s_wrap_frame_start", 32'(fs_s), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
